// File: rtl/inv_sbox_serial_if.sv
// inv_sbox_serial_if: valid/ready input and output channels of the serial inverse S-box
interface inv_sbox_serial_if #(parameter int NIBBLES = 4);
  logic                   in_valid;
  logic                   in_ready;
  logic [4*NIBBLES-1:0]   in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*NIBBLES-1:0]   out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/inv_sbox_serial.sv
// inv_sbox_serial: small-scale AES inverse SubBytes, one nibble per cycle through a single tower-field datapath.
// INV_SBOX_SERIAL_PIPE_EN registers the inverse-affine/basis-in result before the inverter (adds one drain cycle).
module inv_sbox_serial #(
  parameter int NIBBLES = 4
) (
  input logic              clk,
  input logic              rst_n,
  inv_sbox_serial_if.slave bus
);
  localparam int CW = $clog2(NIBBLES + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d, widx;
  logic [4*NIBBLES-1:0] data_q, data_d;
  logic [3:0]           rd, res;
  logic                 we, last;
  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    return {a[1] & b[1] ^ a[1] & b[0] ^ a[0] & b[1], a[1] & b[1] ^ a[0] & b[0]};
  endfunction
  function automatic logic [1:0] gf4_sq(input logic [1:0] a);
    return {a[1], a[1] ^ a[0]};
  endfunction
  function automatic logic [1:0] gf4_mulw(input logic [1:0] a);
    return {a[1] ^ a[0], a[1]};
  endfunction
  // strip the affine constant, undo the linear map, then move x^4+x+1 polynomial basis into the tower basis
  function automatic logic [3:0] aff_in(input logic [3:0] b);
    logic [3:0] t, p;
    t = b ^ 4'h6;
    p = {t[1] ^ t[2] ^ t[3], t[0] ^ t[1] ^ t[2], t[0] ^ t[1] ^ t[3], t[0] ^ t[2] ^ t[3]};
    return {p[3], p[1] ^ p[2] ^ p[3], p[2] ^ p[3], p[0]};
  endfunction
  // GF((2^2)^2) inverse over y^2+y+w; zero falls through to zero naturally
  function automatic logic [3:0] tower_inv(input logic [3:0] t);
    logic [1:0] d, di;
    d  = gf4_mulw(gf4_sq(t[3:2])) ^ gf4_mul(t[3:2], t[1:0]) ^ gf4_sq(t[1:0]);
    di = gf4_sq(d);
    return {gf4_mul(t[3:2], di), gf4_mul(t[3:2] ^ t[1:0], di)};
  endfunction
  function automatic logic [3:0] basis_out(input logic [3:0] t);
    return {t[3], t[1] ^ t[3], t[2] ^ t[1], t[0]};
  endfunction
`ifdef INV_SBOX_SERIAL_PIPE_EN
  logic [3:0] pipe_q;
  assign res  = basis_out(tower_inv(pipe_q));
  assign we   = cnt_q != '0;
  assign widx = CW'(cnt_q - 1'b1);
  assign last = cnt_q == CW'(NIBBLES);
  // pipeline register between the basis-in stage and the inverter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pipe_q <= '0;
    else pipe_q <= aff_in(rd);
`else
  assign res  = basis_out(tower_inv(aff_in(rd)));
  assign we   = 1'b1;
  assign widx = cnt_q;
  assign last = cnt_q == CW'(NIBBLES - 1);
`endif
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.out_data  = data_q;
  // state, nibble counter and working state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  // nibble select, write-back and IDLE/BUSY/DONE sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rd      = '0;
    for (int i = 0; i < NIBBLES; i++)
      if (cnt_q == CW'(i)) rd = data_q[4*i +: 4];
    if (state_q == IDLE && bus.in_valid) begin
      data_d  = bus.in_data;
      cnt_d   = '0;
      state_d = BUSY;
    end else if (state_q == BUSY) begin
      for (int i = 0; i < NIBBLES; i++)
        if (we && widx == CW'(i)) data_d[4*i +: 4] = res;
      cnt_d   = last ? cnt_q : CW'(cnt_q + 1'b1);
      state_d = last ? DONE : BUSY;
    end else if (state_q == DONE && bus.out_ready) begin
      state_d = IDLE;
    end
  end
endmodule
